// File: rtl/wb_regfile_hilo_if.sv
// Bundle between the WB/ID pipeline stages and the GPR + HI/LO register file.
// The master drives the write-back bus and read addresses; the slave returns read data.
interface wb_regfile_hilo_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    localparam int BW = 3 * DW + AW + 2;

    logic [BW-1:0] wb_to_rf_bus;
    logic [AW-1:0] raddr1;
    logic [AW-1:0] raddr2;
    logic [DW-1:0] rdata1;
    logic [DW-1:0] rdata2;
    logic [DW-1:0] hi_rdata;
    logic [DW-1:0] lo_rdata;
    logic          hilo_pending;

    modport master (
        output wb_to_rf_bus, raddr1, raddr2,
        input  rdata1, rdata2, hi_rdata, lo_rdata, hilo_pending
    );

    modport slave (
        input  wb_to_rf_bus, raddr1, raddr2,
        output rdata1, rdata2, hi_rdata, lo_rdata, hilo_pending
    );
endinterface

// File: rtl/wb_regfile_hilo.sv
// 32x32 GPR file plus HI/LO pair, written from the WB bus and read by ID.
// Reads are combinational with write-first bypass of the same-cycle WB write.
module wb_regfile_hilo #(
    parameter int DW   = 32,
    parameter int NREG = 32
) (
    input  logic               clk,
    input  logic               rst,
    wb_regfile_hilo_if.slave   rf
);
    localparam int AW = $clog2(NREG);

    localparam int WDATA_LSB = 0;
    localparam int WADDR_LSB = WDATA_LSB + DW;
    localparam int WE_BIT    = WADDR_LSB + AW;
    localparam int LO_LSB    = WE_BIT + 1;
    localparam int HI_LSB    = LO_LSB + DW;
    localparam int DIV_BIT   = HI_LSB + DW;

    logic          div_flag;
    logic [DW-1:0] hi_wdata;
    logic [DW-1:0] lo_wdata;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;

    assign div_flag = rf.wb_to_rf_bus[DIV_BIT];
    assign hi_wdata = rf.wb_to_rf_bus[HI_LSB +: DW];
    assign lo_wdata = rf.wb_to_rf_bus[LO_LSB +: DW];
    assign rf_we    = rf.wb_to_rf_bus[WE_BIT];
    assign rf_waddr = rf.wb_to_rf_bus[WADDR_LSB +: AW];
    assign rf_wdata = rf.wb_to_rf_bus[WDATA_LSB +: DW];

    logic [DW-1:0] regs [NREG];
    logic [DW-1:0] hi_q;
    logic [DW-1:0] lo_q;
    logic          pending_q;

    logic gpr_wr;
    assign gpr_wr = rf_we && (rf_waddr != '0);

    // Entry 0 is cleared on reset and never written, so it stays zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            hi_q      <= '0;
            lo_q      <= '0;
            pending_q <= 1'b0;
        end else begin
            if (gpr_wr) begin
                regs[rf_waddr] <= rf_wdata;
            end
            if (div_flag) begin
                hi_q <= hi_wdata;
                lo_q <= lo_wdata;
            end
            pending_q <= div_flag;
        end
    end

    // Bypass is left active during reset; WB presents a zero bus then anyway.
    assign rf.rdata1 = (rf.raddr1 == '0)                    ? '0       :
                       (rf_we && (rf_waddr == rf.raddr1))   ? rf_wdata :
                                                              regs[rf.raddr1];

    assign rf.rdata2 = (rf.raddr2 == '0)                    ? '0       :
                       (rf_we && (rf_waddr == rf.raddr2))   ? rf_wdata :
                                                              regs[rf.raddr2];

    assign rf.hi_rdata     = div_flag ? hi_wdata : hi_q;
    assign rf.lo_rdata     = div_flag ? lo_wdata : lo_q;
    assign rf.hilo_pending = pending_q;
endmodule

// File: tb/tb_wb_regfile_hilo.sv
// Directed bench for wb_regfile_hilo: bypass, x0 masking, HI/LO, reset discard.
module tb_wb_regfile_hilo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests  = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    wb_regfile_hilo_if #(.DW(32), .AW(5)) bus_if ();

    wb_regfile_hilo #(.DW(32), .NREG(32)) dut (
        .clk (clk),
        .rst (rst),
        .rf  (bus_if.slave)
    );

    function automatic logic [102:0] mk_bus(input logic div, input logic [31:0] hi,
                                            input logic [31:0] lo, input logic we,
                                            input logic [4:0] wa, input logic [31:0] wd);
        return {div, hi, lo, we, wa, wd};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance through one rising edge and land on the next falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bus_if.wb_to_rf_bus = '0;
        bus_if.raddr1 = '0;
        bus_if.raddr2 = '0;

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        for (int i = 0; i < 32; i++) begin
            bus_if.raddr1 = 5'(i);
            bus_if.raddr2 = 5'(31 - i);
            #1;
            chk($sformatf("reset_rd1_%0d", i), bus_if.rdata1, 32'h0);
            chk($sformatf("reset_rd2_%0d", 31 - i), bus_if.rdata2, 32'h0);
        end
        chk("reset_hi", bus_if.hi_rdata, 32'h0);
        chk("reset_lo", bus_if.lo_rdata, 32'h0);
        chk("reset_pending", {31'h0, bus_if.hilo_pending}, 32'h0);

        // Write-first bypass, then stored value
        @(negedge clk);
        bus_if.wb_to_rf_bus = mk_bus(1'b0, 32'h0, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF);
        bus_if.raddr1 = 5'd5;
        bus_if.raddr2 = 5'd5;
        #1;
        chk("bypass_r5_p1", bus_if.rdata1, 32'hDEADBEEF);
        chk("bypass_r5_p2", bus_if.rdata2, 32'hDEADBEEF);
        step();
        bus_if.wb_to_rf_bus = '0;
        #1;
        chk("stored_r5", bus_if.rdata1, 32'hDEADBEEF);

        // Writes to x0 are ignored
        bus_if.wb_to_rf_bus = mk_bus(1'b0, 32'h0, 32'h0, 1'b1, 5'd0, 32'h12345678);
        bus_if.raddr1 = 5'd0;
        bus_if.raddr2 = 5'd0;
        #1;
        chk("x0_during_p1", bus_if.rdata1, 32'h0);
        chk("x0_during_p2", bus_if.rdata2, 32'h0);
        step();
        bus_if.wb_to_rf_bus = '0;
        #1;
        chk("x0_after_p1", bus_if.rdata1, 32'h0);
        chk("x0_after_p2", bus_if.rdata2, 32'h0);

        // HI/LO and GPR write in the same cycle
        bus_if.wb_to_rf_bus = mk_bus(1'b1, 32'h3, 32'h7, 1'b1, 5'd9, 32'hA5A5A5A5);
        bus_if.raddr1 = 5'd9;
        bus_if.raddr2 = 5'd5;
        #1;
        chk("div_hi_bypass", bus_if.hi_rdata, 32'h3);
        chk("div_lo_bypass", bus_if.lo_rdata, 32'h7);
        chk("div_r9_bypass", bus_if.rdata1, 32'hA5A5A5A5);
        chk("div_r5_other", bus_if.rdata2, 32'hDEADBEEF);
        chk("div_pending_pre", {31'h0, bus_if.hilo_pending}, 32'h0);
        step();
        bus_if.wb_to_rf_bus = '0;
        #1;
        chk("div_hi_stored", bus_if.hi_rdata, 32'h3);
        chk("div_lo_stored", bus_if.lo_rdata, 32'h7);
        chk("div_r9_stored", bus_if.rdata1, 32'hA5A5A5A5);
        chk("div_pending_1", {31'h0, bus_if.hilo_pending}, 32'h1);
        step();
        #1;
        chk("div_pending_0", {31'h0, bus_if.hilo_pending}, 32'h0);
        chk("div_hi_held", bus_if.hi_rdata, 32'h3);

        // Top register on both ports
        bus_if.wb_to_rf_bus = mk_bus(1'b0, 32'h0, 32'h0, 1'b1, 5'd31, 32'hCAFEF00D);
        step();
        bus_if.wb_to_rf_bus = '0;
        bus_if.raddr1 = 5'd31;
        bus_if.raddr2 = 5'd31;
        #1;
        chk("r31_p1", bus_if.rdata1, 32'hCAFEF00D);
        chk("r31_p2", bus_if.rdata2, 32'hCAFEF00D);

        // Reset discards a concurrent write
        bus_if.wb_to_rf_bus = mk_bus(1'b0, 32'h0, 32'h0, 1'b1, 5'd7, 32'h11);
        step();
        bus_if.wb_to_rf_bus = mk_bus(1'b0, 32'h0, 32'h0, 1'b1, 5'd8, 32'h22);
        step();
        bus_if.wb_to_rf_bus = '0;
        bus_if.raddr1 = 5'd7;
        bus_if.raddr2 = 5'd8;
        #1;
        chk("pre_rst_r7", bus_if.rdata1, 32'h11);
        chk("pre_rst_r8", bus_if.rdata2, 32'h22);
        rst = 1'b1;
        bus_if.wb_to_rf_bus = mk_bus(1'b1, 32'hAAAA0000, 32'h0000BBBB, 1'b1, 5'd7, 32'h99);
        #1;
        chk("rst_bypass_r7", bus_if.rdata1, 32'h99);
        chk("rst_bypass_hi", bus_if.hi_rdata, 32'hAAAA0000);
        step();
        rst = 1'b0;
        bus_if.wb_to_rf_bus = '0;
        #1;
        chk("post_rst_r7", bus_if.rdata1, 32'h0);
        chk("post_rst_r8", bus_if.rdata2, 32'h0);
        chk("post_rst_hi", bus_if.hi_rdata, 32'h0);
        chk("post_rst_lo", bus_if.lo_rdata, 32'h0);
        chk("post_rst_pending", {31'h0, bus_if.hilo_pending}, 32'h0);
        bus_if.raddr1 = 5'd9;
        bus_if.raddr2 = 5'd31;
        #1;
        chk("post_rst_r9", bus_if.rdata1, 32'h0);
        chk("post_rst_r31", bus_if.rdata2, 32'h0);

        // Back-to-back writes to r3
        bus_if.raddr1 = 5'd5;
        bus_if.raddr2 = 5'd3;
        bus_if.wb_to_rf_bus = mk_bus(1'b0, 32'h0, 32'h0, 1'b1, 5'd3, 32'h1);
        #1;
        chk("b2b_r3_first", bus_if.rdata2, 32'h1);
        chk("b2b_r5_nohit", bus_if.rdata1, 32'h0);
        step();
        bus_if.wb_to_rf_bus = mk_bus(1'b0, 32'h0, 32'h0, 1'b1, 5'd3, 32'h2);
        #1;
        chk("b2b_r3_second", bus_if.rdata2, 32'h2);
        step();
        bus_if.wb_to_rf_bus = '0;
        #1;
        chk("b2b_r3_stored", bus_if.rdata2, 32'h2);

        // Zero bus is a no-op
        step();
        #1;
        chk("bubble_r3", bus_if.rdata2, 32'h2);
        chk("bubble_hi", bus_if.hi_rdata, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/wb_regfile_hilo.md
Name: wb_regfile_hilo

Overview:
- Receiving end of the WB-to-register-file bus: 32x32 general-purpose register file plus the HI/LO register pair.
- Consumes the write-back bus emitted by the WB stage and serves ID-stage operand reads.
- Provides write-first bypass so ID observes same-cycle WB writes.
- The HI/LO read port serves MFHI/MFLO decode.

Parameters:
- DW, 32, data width of GPRs, HI and LO.
- NREG, 32, number of GPRs; address width is 5.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- wb_to_rf_bus  input  103  write-back bus, fields:
  - [102] div_flag
  - [101:70] hi_wdata (div_result[63:32], remainder)
  - [69:38] lo_wdata (div_result[31:0], quotient)
  - [37] rf_we
  - [36:32] rf_waddr
  - [31:0] rf_wdata
- raddr1  input  5  read port 1 address (rs).
- raddr2  input  5  read port 2 address (rt).
- rdata1  output  32  read port 1 data, combinational.
- rdata2  output  32  read port 2 data, combinational.
- hi_rdata  output  32  current HI value with bypass.
- lo_rdata  output  32  current LO value with bypass.
- hilo_pending  output  1  registered; high the cycle after a HI/LO write was committed.

Behaviour:
- Clock and reset: one clock (clk); synchronous active-high reset (rst).
- On rst at a clock edge:
  - All GPRs, HI and LO clear to 0.
  - hilo_pending clears to 0.
  - A bus write presented in the same cycle is discarded.
- GPR write:
  - At the edge, if rf_we=1 and rf_waddr!=0, reg[rf_waddr] <= rf_wdata.
  - A write to address 0 is ignored; reg0 always reads 0.
- HI/LO write:
  - At the edge, if div_flag=1, HI <= hi_wdata and LO <= lo_wdata, both updated atomically.
  - div_flag and rf_we are independent; both may be high in one cycle, and both writes commit.
- Reads:
  - Combinational, zero latency.
  - Priority for rdataN:
    1. raddrN==0 -> 0.
    2. Else if rf_we=1 and rf_waddr==raddrN -> rf_wdata (write-first bypass).
    3. Else reg[raddrN].
  - Both read ports may hit the same address or the bypass simultaneously; each resolves independently.
  - hi_rdata = div_flag ? hi_wdata : HI. lo_rdata = div_flag ? lo_wdata : LO.
- Bypass during reset: bypass paths are active even while rst=1 (the bus is zero during WB reset/bubble), so no special masking is needed.
- hilo_pending <= div_flag & ~rst. It is a diagnostic strobe for verification/perf counters and has no functional effect.
- Stalls and bubbles:
  - No stall input. The WB stage delivers an all-zero bus during bubbles.
  - An all-zero bus produces no state change.
- The register array contains no X after reset; reads of never-written registers return 0.

Test Plan:
- Reset then read all 32 addresses on both ports -> every rdata1/rdata2 = 0x00000000; hi_rdata = lo_rdata = 0.
- Write rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF with raddr1=5 in the same cycle:
  - -> rdata1 = 0xDEADBEEF combinationally (bypass).
  - Next cycle with rf_we=0 -> rdata1 still 0xDEADBEEF (stored).
- Write rf_waddr=0, rf_wdata=0x12345678 with raddr1=raddr2=0 -> rdata1 = rdata2 = 0 during and after the write.
- div_flag=1, div_result=0x00000003_00000007, together with rf_we=1, waddr=9, wdata=0xA5A5A5A5:
  - -> hi_rdata=3 and lo_rdata=7 same cycle; next cycle HI=3, LO=7, reg9=0xA5A5A5A5.
  - hilo_pending=1 for exactly one cycle.
- Write reg7=0x11 and reg8=0x22, then assert rst together with rf_we=1, waddr=7, wdata=0x99:
  - -> after the edge, reg7=0, reg8=0, HI=LO=0; the write is discarded.
- Back-to-back writes to reg3 on consecutive cycles (0x1, then 0x2) with raddr2=3 each cycle -> rdata2 = 0x1, then 0x2; stored value after the final edge = 0x2.
